flag_unit: RTL and testbench

//  Consumer end of the ALU flag interface: registers carry/sign/zero from the ALU into the CCR.
//  Per-instruction update masks, explicit SETC/CLRC, and flag-consuming conditional branches (JZ/JN/JC).

---
 rtl/flag_unit_pkg.sv | 43 ++++
 rtl/flag_stack.sv | 62 ++++++
 rtl/flag_unit.sv | 98 +++++++++
 tb/tb_flag_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_unit_pkg.sv
// Shared definitions for the flag unit: branch condition codes, CCR bit
// positions and small helpers for evaluating/clearing the tested flag.
package flag_unit_pkg;

    typedef enum logic [1:0] {
        BR_JZ  = 2'b00,
        BR_JN  = 2'b01,
        BR_JC  = 2'b10,
        BR_JMP = 2'b11
    } br_cond_e;

    localparam int FLAG_W = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // True when the flag selected by cond is set (JMP is always true).
    function automatic logic cond_met(input logic [FLAG_W-1:0] flags,
                                      input logic [1:0]        cond);
        logic met;
        case (cond)
            BR_JZ:   met = flags[FLAG_Z];
            BR_JN:   met = flags[FLAG_N];
            BR_JC:   met = flags[FLAG_C];
            default: met = 1'b1;
        endcase
        return met;
    endfunction

    // One-hot mask of the flag a conditional branch tests; empty for JMP.
    function automatic logic [FLAG_W-1:0] tested_mask(input logic [1:0] cond);
        logic [FLAG_W-1:0] m;
        m = '0;
        case (cond)
            BR_JZ:   m[FLAG_Z] = 1'b1;
            BR_JN:   m[FLAG_N] = 1'b1;
            BR_JC:   m[FLAG_C] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// Interrupt save LIFO for the CCR. A pop and a push in the same cycle are
// resolved pop-first, so a valid pop+push replaces the top entry. Misuse
// (push when full, pop when empty) raises a sticky error flag.
module flag_stack
    import flag_unit_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] din,
    output logic [FLAG_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int DW = $clog2(SHADOW_DEPTH + 1);
    localparam logic [DW-1:0] FULL_LVL = DW'(SHADOW_DEPTH);

    logic [FLAG_W-1:0] mem [0:(1<<DW)-1];
    logic [DW-1:0]     depth;
    logic [DW-1:0]     depth_popped;
    logic [DW-1:0]     depth_nxt;
    logic              pop_ok;
    logic              push_ok;
    logic              err_q;

    assign empty = (depth == '0);
    assign full  = (depth == FULL_LVL);
    assign dout  = empty ? '0 : mem[depth - 1'b1];
    assign err   = err_q;

    // Pop first, then decide whether the push still fits.
    always_comb begin
        pop_ok       = pop & ~empty;
        depth_popped = pop_ok ? depth - 1'b1 : depth;
        push_ok      = push & (depth_popped != FULL_LVL);
        depth_nxt    = push_ok ? depth_popped + 1'b1 : depth_popped;
    end

    // Depth pointer and sticky misuse flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
            err_q <= 1'b0;
        end else begin
            depth <= depth_nxt;
            err_q <= err_q | (pop & empty) | (push & ~push_ok);
        end
    end

    // Storage needs no reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[depth_popped] <= din;
        end
    end

endmodule

// File: rtl/flag_unit.sv
// Flag unit: registers ALU carry/sign/zero into the CCR under per-flag
// masks, handles SETC/CLRC, evaluates JZ/JN/JC/JMP and saves/restores the
// CCR across nested interrupts.
// Build option FLAG_FWD_EN: when defined, branches test the flags produced
// by this cycle's ALU/SETC/CLRC update; otherwise they test the registered CCR.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    parameter bit CLR_ON_TAKEN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aluValid,
    input  logic [2:0]        updMask,
    input  logic              carryIn,
    input  logic              signIn,
    input  logic              zeroIn,
    input  logic              setC,
    input  logic              clrC,
    input  logic              brValid,
    input  logic [1:0]        brCond,
    input  logic              intSave,
    input  logic              intRestore,
    output logic              brTaken,
    output logic [FLAG_W-1:0] ccr,
    output logic              inIsr,
    output logic              nestErr
);

    logic [FLAG_W-1:0] ccr_q;
    logic [FLAG_W-1:0] upd;
    logic [FLAG_W-1:0] test_src;
    logic [FLAG_W-1:0] pre;
    logic [FLAG_W-1:0] nxt;
    logic [FLAG_W-1:0] pop_val;
    logic              taken;
    logic              stk_empty;
    logic              stk_err;
    logic              unused_full;

    // Next-CCR: ALU update, SETC/CLRC, branch clear, then restore override.
    always_comb begin
        upd = ccr_q;
        if (aluValid) begin
            if (updMask[FLAG_C]) upd[FLAG_C] = carryIn;
            if (updMask[FLAG_N]) upd[FLAG_N] = signIn;
            if (updMask[FLAG_Z]) upd[FLAG_Z] = zeroIn;
        end
        if (clrC) begin
            upd[FLAG_C] = 1'b0;
        end else if (setC) begin
            upd[FLAG_C] = 1'b1;
        end
`ifdef FLAG_FWD_EN
        test_src = upd;
`else
        test_src = ccr_q;
`endif
        taken = brValid & ~rst & cond_met(test_src, brCond);
        pre   = upd;
        if (taken && CLR_ON_TAKEN) begin
            pre = upd & ~tested_mask(brCond);
        end
        nxt = (intRestore & ~stk_empty) ? pop_val : pre;
    end

    // CCR register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr_q <= '0;
        end else begin
            ccr_q <= nxt;
        end
    end

    // The pushed value is the pre-restore next-CCR so a same-cycle
    // pop+push stores this cycle's flags on top.
    flag_stack #(
        .SHADOW_DEPTH (SHADOW_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (intSave),
        .pop   (intRestore),
        .din   (pre),
        .dout  (pop_val),
        .empty (stk_empty),
        .full  (unused_full),
        .err   (stk_err)
    );

    assign brTaken = taken;
    assign ccr     = ccr_q;
    assign inIsr   = ~stk_empty;
    assign nestErr = stk_err;

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed vector table, a reset-during-ISR sequence,
// and randomized traffic against a behavioural model.
module tb_flag_unit;

    localparam int DEPTH = 2;
    localparam bit CLR   = 1'b1;
`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       aluValid = 1'b0;
    logic [2:0] updMask = '0;
    logic       carryIn = 1'b0;
    logic       signIn = 1'b0;
    logic       zeroIn = 1'b0;
    logic       setC = 1'b0;
    logic       clrC = 1'b0;
    logic       brValid = 1'b0;
    logic [1:0] brCond = '0;
    logic       intSave = 1'b0;
    logic       intRestore = 1'b0;
    logic       brTaken;
    logic [2:0] ccr;
    logic       inIsr;
    logic       nestErr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flag_unit #(
        .SHADOW_DEPTH (DEPTH),
        .CLR_ON_TAKEN (CLR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .aluValid   (aluValid),
        .updMask    (updMask),
        .carryIn    (carryIn),
        .signIn     (signIn),
        .zeroIn     (zeroIn),
        .setC       (setC),
        .clrC       (clrC),
        .brValid    (brValid),
        .brCond     (brCond),
        .intSave    (intSave),
        .intRestore (intRestore),
        .brTaken    (brTaken),
        .ccr        (ccr),
        .inIsr      (inIsr),
        .nestErr    (nestErr)
    );

    typedef struct {
        logic       alu;
        logic [2:0] mask;
        logic [2:0] fl;      // {carry, sign, zero}
        logic       setc;
        logic       clrc;
        logic       brv;
        logic [1:0] cond;
        logic       save;
        logic       rest;
        logic       exp_br;
        logic [2:0] exp_ccr;
        logic       exp_isr;
        logic       exp_err;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state: CCR, LIFO as a queue, sticky error.
    logic [2:0] m_ccr;
    logic [2:0] m_q[$];
    logic       m_err;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic alu, input logic [2:0] mask, input logic [2:0] fl,
                       input logic setc, input logic clrc, input logic brv,
                       input logic [1:0] cond, input logic save, input logic rest,
                       input logic exp_br, input logic [2:0] exp_ccr,
                       input logic exp_isr, input logic exp_err);
        vec_t v;
        v.alu = alu; v.mask = mask; v.fl = fl; v.setc = setc; v.clrc = clrc;
        v.brv = brv; v.cond = cond; v.save = save; v.rest = rest;
        v.exp_br = exp_br; v.exp_ccr = exp_ccr; v.exp_isr = exp_isr; v.exp_err = exp_err;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        aluValid   = v.alu;
        updMask    = v.mask;
        carryIn    = v.fl[2];
        signIn     = v.fl[1];
        zeroIn     = v.fl[0];
        setC       = v.setc;
        clrC       = v.clrc;
        brValid    = v.brv;
        brCond     = v.cond;
        intSave    = v.save;
        intRestore = v.rest;
    endtask

    task automatic idle();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        m_ccr = '0;
        m_q.delete();
        m_err = 1'b0;
    endtask

    // Model one cycle from the spec rules; returns the expected branch decision.
    task automatic model_step(output logic exp_br);
        logic c, n, z, t;
        logic [2:0] src, pre, nx;
        {c, n, z} = m_ccr;
        if (aluValid) begin
            if (updMask[2]) c = carryIn;
            if (updMask[1]) n = signIn;
            if (updMask[0]) z = zeroIn;
        end
        if (clrC) c = 1'b0;
        else if (setC) c = 1'b1;
        src = FWD ? {c, n, z} : m_ccr;
        case (brCond)
            2'd0:    t = src[0];
            2'd1:    t = src[1];
            2'd2:    t = src[2];
            default: t = 1'b1;
        endcase
        exp_br = brValid & t;
        if (exp_br && CLR) begin
            if (brCond == 2'd0) z = 1'b0;
            if (brCond == 2'd1) n = 1'b0;
            if (brCond == 2'd2) c = 1'b0;
        end
        pre = {c, n, z};
        nx  = pre;
        if (intRestore) begin
            if (m_q.size() > 0) nx = m_q.pop_back();
            else m_err = 1'b1;
        end
        if (intSave) begin
            if (m_q.size() < DEPTH) m_q.push_back(pre);
            else m_err = 1'b1;
        end
        m_ccr = nx;
    endtask

    initial begin
        logic eb;

        // Directed table.
        add(1, 3'b111, 3'b101, 0, 0, 0, 0, 0, 0, 0, 3'b101, 0, 0);
        add(1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0);
        add(1, 3'b111, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0);
        add(0, 3'b000, 3'b000, 0, 0, 1, 0, 0, 0, 1, 3'b000, 0, 0);
        add(0, 3'b000, 3'b000, 0, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0);
        add(1, 3'b001, 3'b001, 0, 0, 1, 0, 0, 0, FWD, FWD ? 3'b000 : 3'b001, 0, 0);
        add(1, 3'b111, 3'b100, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0);
        add(0, 3'b000, 3'b000, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        add(0, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0);
        add(1, 3'b111, 3'b011, 0, 0, 0, 0, 0, 0, 0, 3'b011, 0, 0);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0, 3'b011, 1, 0);
        add(1, 3'b111, 3'b100, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 0, 3'b011, 0, 0);
        add(0, 3'b000, 3'b000, 0, 0, 1, 1, 0, 0, 1, 3'b001, 0, 0);
        add(0, 3'b000, 3'b000, 0, 0, 1, 2, 0, 0, 0, 3'b001, 0, 0);
        add(0, 3'b000, 3'b000, 0, 0, 1, 3, 0, 0, 1, 3'b001, 0, 0);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0, 3'b001, 1, 0);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0, 3'b001, 1, 0);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0, 3'b001, 1, 1);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 0, 3'b001, 1, 1);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 0, 3'b001, 0, 1);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0, 3'b001, 1, 1);
        add(1, 3'b111, 3'b111, 0, 0, 0, 0, 1, 1, 0, 3'b001, 1, 1);
        add(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 0, 3'b111, 0, 1);

        // Reset state, with an unconditional branch presented during reset.
        idle();
        brValid = 1'b1;
        brCond  = 2'd3;
        #1;
        chk("reset_brTaken", {2'b0, brTaken}, 3'b000);
        @(negedge clk);
        chk("reset_ccr", ccr, 3'b000);
        chk("reset_inIsr", {2'b0, inIsr}, 3'b000);
        chk("reset_nestErr", {2'b0, nestErr}, 3'b000);
        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d_brTaken", i), {2'b0, brTaken}, {2'b0, tbl[i].exp_br});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ccr", i), ccr, tbl[i].exp_ccr);
            chk($sformatf("vec%0d_inIsr", i), {2'b0, inIsr}, {2'b0, tbl[i].exp_isr});
            chk($sformatf("vec%0d_nestErr", i), {2'b0, nestErr}, {2'b0, tbl[i].exp_err});
            @(negedge clk);
        end

        // Reset while inside an ISR discards the LIFO and clears the error.
        idle();
        intSave = 1'b1;
        @(posedge clk);
        #1;
        chk("isr_before_rst", {2'b0, inIsr}, 3'b001);
        #2;
        idle();
        rst     = 1'b1;
        brValid = 1'b1;
        brCond  = 2'd3;
        #1;
        chk("midrst_ccr", ccr, 3'b000);
        chk("midrst_inIsr", {2'b0, inIsr}, 3'b000);
        chk("midrst_nestErr", {2'b0, nestErr}, 3'b000);
        chk("midrst_brTaken", {2'b0, brTaken}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        idle();
        intRestore = 1'b1;
        aluValid   = 1'b1;
        updMask    = 3'b010;
        signIn     = 1'b1;
        @(posedge clk);
        #1;
        chk("pop_empty_ccr", ccr, 3'b010);
        chk("pop_empty_inIsr", {2'b0, inIsr}, 3'b000);
        chk("pop_empty_nestErr", {2'b0, nestErr}, 3'b001);
        @(negedge clk);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            aluValid   = $urandom_range(0, 1);
            updMask    = 3'($urandom_range(0, 7));
            carryIn    = $urandom_range(0, 1);
            signIn     = $urandom_range(0, 1);
            zeroIn     = $urandom_range(0, 1);
            setC       = ($urandom_range(0, 3) == 0);
            clrC       = ($urandom_range(0, 3) == 0);
            brValid    = $urandom_range(0, 1);
            brCond     = 2'($urandom_range(0, 3));
            intSave    = ($urandom_range(0, 3) == 0);
            intRestore = ($urandom_range(0, 3) == 0);
            #1;
            model_step(eb);
            chk("rnd_brTaken", {2'b0, brTaken}, {2'b0, eb});
            @(posedge clk);
            #1;
            chk("rnd_ccr", ccr, m_ccr);
            chk("rnd_inIsr", {2'b0, inIsr}, {2'b0, (m_q.size() != 0)});
            chk("rnd_nestErr", {2'b0, nestErr}, {2'b0, m_err});
            @(negedge clk);
            if (k % 150 == 149) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
